jk_bank_sequencer: RTL and testbench

- Owns a bank of WIDTH JK flip-flop cells and shares write access among NREQ requesters.
- Each requester submits a command over a valid/ready handshake: a 2-bit JK op, a target cell index, and a repeat count.
- A round-robin arbiter accepts one command at a time. A two-state sequencer applies the op to the target cell on cnt+1 consecutive clock edges, then pulses done.

---
 rtl/jk_bank_sequencer_if.sv | 17 +
 rtl/jk_bank_sequencer.sv | 113 +++++++++++
 tb/tb_jk_bank_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
// jk_bank_sequencer_if: packed per-requester command bus (valid/ready + op/idx/cnt payload)
//   valid[r], ready[r]  handshake for requester r
//   op[2r+1:2r]         JK op: 00 hold, 01 reset, 10 set, 11 toggle
//   idx, cnt            target cell index and repeat count, IDXW/CNTW bits per requester
interface jk_bank_sequencer_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 3,
  parameter int CNTW = 4
);
  logic [NREQ-1:0] valid;
  logic [NREQ-1:0] ready;
  logic [2*NREQ-1:0] op;
  logic [IDXW*NREQ-1:0] idx;
  logic [CNTW*NREQ-1:0] cnt;
  modport master(output valid, op, idx, cnt, input ready);
  modport slave(input valid, op, idx, cnt, output ready);
endinterface

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: round-robin shared bank of JK cells, each command applied cnt+1 times
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req             slave side of the request bus
//   q               JK cell states
//   busy            high while executing a command
//   done/done_id    one-cycle completion pulse and the requester it belongs to
//   err             qualifies done: target index was outside the bank
module jk_bank_sequencer #(
  parameter int NREQ = 4,
  parameter int WIDTH = 6,
  parameter int IDXW = 3,
  parameter int CNTW = 4,
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic clk,
  input  logic reset,
  jk_bank_sequencer_if.slave req,
  output logic [WIDTH-1:0] q,
  output logic busy,
  output logic done,
  output logic [IDW-1:0] done_id,
  output logic err
);
  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, done_id_q, done_id_d, g;
  logic [1:0] op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] cell_q, cell_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, found;
  // rotated-priority search starting just after the last winner
  always_comb begin
    found = 1'b0;
    g = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req.valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        g = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  assign req.ready = (!reset && state_q == IDLE && found) ? NREQ'(1) << g : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    op_d = op_q;
    idx_d = idx_q;
    rem_d = rem_q;
    cell_d = cell_q;
    busy_d = busy_q;
    done_d = 1'b0;
    done_id_d = done_id_q;
    err_d = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = EXEC;
        busy_d = 1'b1;
        ptr_d = g;
        id_d = g;
        op_d = req.op[2*g +: 2];
        idx_d = req.idx[IDXW*g +: IDXW];
        rem_d = req.cnt[CNTW*g +: CNTW];
      end
    end else begin
      // out-of-range idx matches no cell, so the bank is left untouched
      for (int i = 0; i < WIDTH; i++)
        if (int'(idx_q) == i) cell_d[i] = op_q == 2'b11 ? ~cell_q[i] : op_q == 2'b00 ? cell_q[i] : op_q[1];
      if (rem_q == '0) begin
        state_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        done_id_d = id_q;
        err_d = int'(idx_q) >= WIDTH;
      end else begin
        rem_d = rem_q - 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= IDW'(NREQ - 1);
      id_q <= '0;
      op_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
      cell_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      done_id_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      op_q <= op_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
      cell_q <= cell_d;
      busy_q <= busy_d;
      done_q <= done_d;
      done_id_q <= done_id_d;
      err_q <= err_d;
    end
  end
  assign q = cell_q;
  assign busy = busy_q;
  assign done = done_q;
  assign done_id = done_id_q;
  assign err = err_q;
endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer: directed and randomized command streams checked against a transaction model
module tb_jk_bank_sequencer;
  localparam int NREQ = 4, WIDTH = 6, IDXW = 3, CNTW = 4;
  logic clk = 1'b0, reset;
  logic [WIDTH-1:0] q;
  logic busy, done, err;
  logic [1:0] done_id;
  jk_bank_sequencer_if #(.NREQ(NREQ), .IDXW(IDXW), .CNTW(CNTW)) bus ();
  jk_bank_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .req(bus.slave), .q(q), .busy(busy), .done(done), .done_id(done_id), .err(err));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [NREQ-1:0] pend = '0;
  logic [1:0] p_op[NREQ];
  logic [IDXW-1:0] p_idx[NREQ];
  logic [CNTW-1:0] p_cnt[NREQ];
  logic [WIDTH-1:0] mq;
  int ptr, w;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [WIDTH-1:0] apply(input logic [WIDTH-1:0] m, input logic [1:0] o, input int ix);
    if (ix < WIDTH && o != 2'd0) m[ix] = (o == 2'd3) ? ~m[ix] : (o == 2'd2);
    return m;
  endfunction
  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      bus.valid[r] = pend[r];
      bus.op[2*r +: 2] = p_op[r];
      bus.idx[IDXW*r +: IDXW] = p_idx[r];
      bus.cnt[CNTW*r +: CNTW] = p_cnt[r];
    end
  endtask
  task automatic issue(input int r, input logic [1:0] o, input int ix, input int c);
    pend[r] = 1'b1;
    p_op[r] = o;
    p_idx[r] = IDXW'(ix);
    p_cnt[r] = CNTW'(c);
  endtask
  // one full command: grant check, cnt+1 EXEC cycles, done cycle; returns at the done negedge
  task automatic serve(output int win);
    logic [1:0] o;
    int ix, c;
    drive();
    #1;
    win = -1;
    for (int k = 1; k <= NREQ; k++) if (win < 0 && pend[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
    if (win < 0) begin
      $display("FAIL serve: no pending request");
      return;
    end
    chk("grant", 32'(bus.ready), 32'(1) << win);
    chk("idle_busy", 32'(busy), 0);
    o = p_op[win];
    ix = int'(p_idx[win]);
    c = int'(p_cnt[win]);
    ptr = win;
    for (int k = 0; k <= c; k++) begin
      @(negedge clk);
      chk("exec_busy", 32'(busy), 1);
      chk("exec_done", 32'(done), 0);
      chk("exec_ready", 32'(bus.ready), 0);
      chk("exec_q", 32'(q), 32'(mq));
      if (k == 0) begin
        pend[win] = 1'b0;
        drive();
      end
      mq = apply(mq, o, ix);
    end
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("done_id", 32'(done_id), 32'(win));
    chk("err", 32'(err), 32'(ix >= WIDTH));
    chk("done_busy", 32'(busy), 0);
    chk("done_q", 32'(q), 32'(mq));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int r = 0; r < NREQ; r++) issue(r, 2'd0, 0, 0);
    reset = 1'b1;
    drive();
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready", 32'(bus.ready), 0);
    pend = '0;
    drive();
    @(negedge clk);
    reset = 1'b0;
    mq = '0;
    ptr = NREQ - 1;
    issue(0, 2'd2, 2, 0);
    serve(w);
    issue(1, 2'd3, 5, 2);
    serve(w);
    for (int r = 0; r < NREQ; r++) issue(r, 2'd0, r, 0);
    repeat (5) begin
      serve(w);
      issue(w, 2'd0, w, 0);
    end
    while (pend != '0) serve(w);
    issue(2, 2'd2, 6, 1);
    serve(w);
    issue(3, 2'd3, 0, 7);
    drive();
    #1;
    chk("mid_grant", 32'(bus.ready), 32'(1) << 3);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_q", 32'(q), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_ready", 32'(bus.ready), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    mq = '0;
    ptr = NREQ - 1;
    #1;
    chk("rel_done", 32'(done), 0);
    issue(1, 2'd2, 1, 0);
    serve(w);
    serve(w);
    issue(0, 2'd1, 1, 15);
    issue(1, 2'd2, 1, 0);
    serve(w);
    serve(w);
    repeat (60) begin
      for (int r = 0; r < NREQ; r++)
        if (!pend[r] && $urandom_range(0, 2) == 0)
          issue(r, 2'($urandom_range(0, 3)), $urandom_range(0, 7), ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3));
      if (pend == '0) begin
        @(negedge clk);
        drive();
        #1;
        chk("idle_ready", 32'(bus.ready), 0);
        chk("idle_busy2", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
      end else begin
        serve(w);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
